// File: rtl/boot_loader.sv
// boot_loader: writes a framed byte stream (LEN, data, CSUM) into the CPU program RAM,
// zero-fills the unused tail and keeps the CPU held in reset until a valid image is in place.
module boot_loader #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_FILL,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [AW:0]   N_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   N_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
    localparam logic [DW-1:0] LEN_MAX  = DW'(DEPTH);

    state_t        state;
    state_t        state_next;
    logic [AW:0]   n_len;
    logic [AW:0]   n_len_next;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_next;
    logic [DW-1:0] sum;
    logic [DW-1:0] sum_next;
    logic          wr_en_next;
    logic [AW-1:0] wr_addr_next;
    logic [DW-1:0] wr_data_next;
    logic          xfer;

    assign xfer = rx_valid && rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // N is one bit wider than the index so that a full-depth image (LEN = 0) is representable.
    always_comb begin
        state_next   = state;
        n_len_next   = n_len;
        idx_next     = idx;
        sum_next     = sum;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr;
        wr_data_next = wr_data;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if (rx_data > LEN_MAX) begin
                        state_next = S_ERROR;
                    end else begin
                        n_len_next = (rx_data == '0) ? N_FULL : rx_data[AW:0];
                        idx_next   = '0;
                        sum_next   = '0;
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = idx;
                    wr_data_next = rx_data;
                    sum_next     = sum + rx_data;
                    idx_next     = idx + IDX_ONE;
                    if ({1'b0, idx} == n_len - N_ONE) begin
                        state_next = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (rx_data != sum) begin
                        state_next = S_ERROR;
                    end else if (n_len == N_FULL) begin
                        state_next = S_DONE;
                    end else begin
                        // The first zero-fill write is issued straight from the checksum byte.
                        wr_en_next   = 1'b1;
                        wr_addr_next = n_len[AW-1:0];
                        wr_data_next = '0;
                        idx_next     = n_len[AW-1:0];
                        state_next   = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (idx == IDX_LAST) begin
                    state_next = S_DONE;
                end else begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = idx + IDX_ONE;
                    wr_data_next = '0;
                    idx_next     = idx + IDX_ONE;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_next = S_LEN;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered copies of the next-state decode, so they track the state exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_len    <= '0;
            idx      <= '0;
            sum      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rx_ready <= 1'b0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            n_len    <= n_len_next;
            idx      <= idx_next;
            sum      <= sum_next;
            wr_en    <= wr_en_next;
            wr_addr  <= wr_addr_next;
            wr_data  <= wr_data_next;
            rx_ready <= (state_next == S_LEN) || (state_next == S_DATA) || (state_next == S_CSUM);
            cpu_hold <= (state_next != S_DONE);
            done     <= (state_next == S_DONE);
            err      <= (state_next == S_ERROR);
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: drives framed loads with random valid gaps and compares RAM writes,
// completion latency and status against a frame-level reference model.
module tb_boot_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold;
    logic       done;
    logic       err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  tx_q[$];
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];

    typedef struct {
        logic [7:0] len;
        logic [7:0] csum_adj;
        bit         exp_done;
        bit         exp_err;
        int         exp_writes;
        int         exp_lat;
    } vec_t;

    vec_t vecs[9];

    boot_loader #(.DW(8), .AW(4), .DEPTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_en) obs_q.push_back({wr_addr, wr_data});
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offers one byte until it is taken, with random bubbles; junk data rides on bubbles.
    task automatic applyStimulus(input logic [7:0] b, input int pct, input bit with_start, output bit ok);
        int budget = 0;
        bit acc = 1'b0;
        while (!acc && budget < 200) begin
            rx_valid = ($urandom_range(0, 99) < pct);
            rx_data  = rx_valid ? b : 8'($urandom);
            start    = with_start;
            acc      = rx_valid && rx_ready;
            tick();
            budget++;
        end
        start    = 1'b0;
        rx_valid = 1'b0;
        ok       = acc;
    endtask

    task automatic build_model(output bit ed, output bit ee, output int elat);
        int n;
        logic [7:0] s;
        exp_q.delete();
        ed = 1'b0;
        ee = 1'b0;
        elat = 1;
        if (int'(tx_q[0]) > 16) begin
            ee = 1'b1;
            return;
        end
        n = (tx_q[0] == 8'h00) ? 16 : int'(tx_q[0]);
        s = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({4'(i), tx_q[i+1]});
            s += tx_q[i+1];
        end
        if (tx_q[n+1] != s) begin
            ee = 1'b1;
            return;
        end
        for (int a = n; a < 16; a++) exp_q.push_back({4'(a), 8'h00});
        ed = 1'b1;
        elat = 16 - n + 1;
    endtask

    task automatic make_frame(input logic [7:0] len, input logic [7:0] adj);
        int n;
        logic [7:0] s = 8'h00;
        logic [7:0] b;
        tx_q.delete();
        tx_q.push_back(len);
        if (int'(len) <= 16) begin
            n = (len == 8'h00) ? 16 : int'(len);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                tx_q.push_back(b);
                s += b;
            end
            tx_q.push_back(s + adj);
        end
    endtask

    task automatic compare_writes(input string tag);
        checkOutput({tag, " write_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            checkOutput($sformatf("%s write[%0d]", tag, i), int'(obs_q[i]), int'(exp_q[i]));
    endtask

    task automatic run_frame(input int pct, input bit ed, input bit ee, input int elat, input string tag);
        bit ok;
        int lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput({tag, " ready_after_start"}, int'(rx_ready), 1);
        checkOutput({tag, " err_cleared"}, int'(err), 0);
        obs_q.delete();
        foreach (tx_q[i]) begin
            applyStimulus(tx_q[i], pct, 1'b0, ok);
            if (!ok) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL %s accept: byte %0d got not accepted expected accepted", tag, i);
                return;
            end
        end
        lat = 1;
        while (!(done || err) && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput({tag, " latency"}, lat, elat);
        checkOutput({tag, " done"}, int'(done), int'(ed));
        checkOutput({tag, " err"}, int'(err), int'(ee));
        checkOutput({tag, " cpu_hold"}, int'(cpu_hold), int'(!ed));
        checkOutput({tag, " ready_idle"}, int'(rx_ready), 0);
        compare_writes(tag);
    endtask

    initial begin
        bit ok;
        bit all_ok;
        bit ed;
        bit ee;
        int elat;
        logic [7:0] len;
        logic [7:0] adj;

        vecs[0] = '{8'd1,   8'h00, 1'b1, 1'b0, 16, 16};
        vecs[1] = '{8'd5,   8'h00, 1'b1, 1'b0, 16, 12};
        vecs[2] = '{8'd15,  8'h00, 1'b1, 1'b0, 16, 2};
        vecs[3] = '{8'd16,  8'h00, 1'b1, 1'b0, 16, 1};
        vecs[4] = '{8'd0,   8'h00, 1'b1, 1'b0, 16, 1};
        vecs[5] = '{8'd7,   8'h01, 1'b0, 1'b1, 7,  1};
        vecs[6] = '{8'd0,   8'h80, 1'b0, 1'b1, 16, 1};
        vecs[7] = '{8'd17,  8'h00, 1'b0, 1'b1, 0,  1};
        vecs[8] = '{8'd255, 8'h00, 1'b0, 1'b1, 0,  1};

        reset = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        obs_q.delete();
        repeat (5) tick();
        checkOutput("idle cpu_hold", int'(cpu_hold), 1);
        checkOutput("idle rx_ready", int'(rx_ready), 0);
        checkOutput("idle done", int'(done), 0);
        checkOutput("idle err", int'(err), 0);
        checkOutput("idle wr_addr", int'(wr_addr), 0);
        checkOutput("idle wr_data", int'(wr_data), 0);
        checkOutput("idle no_writes", obs_q.size(), 0);

        // Three-byte image: three data writes then thirteen zero-fill writes.
        tx_q = '{8'h03, 8'h86, 8'h45, 8'h21, 8'hEC};
        exp_q = '{12'h086, 12'h145, 12'h221};
        for (int a = 3; a < 16; a++) exp_q.push_back({4'(a), 8'h00});
        run_frame(100, 1'b1, 1'b0, 14, "len3");

        tx_q.delete();
        exp_q.delete();
        tx_q.push_back(8'h00);
        for (int i = 1; i <= 16; i++) begin
            tx_q.push_back(8'(i));
            exp_q.push_back({4'(i - 1), 8'(i)});
        end
        tx_q.push_back(8'h88);
        run_frame(100, 1'b1, 1'b0, 1, "full16");

        tx_q[17] = 8'h4D;
        run_frame(100, 1'b0, 1'b1, 1, "badsum");
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restart err", int'(err), 0);
        checkOutput("restart rx_ready", int'(rx_ready), 1);

        applyStimulus(8'h11, 100, 1'b0, ok);
        checkOutput("badlen accepted", int'(ok), 1);
        checkOutput("badlen err", int'(err), 1);
        checkOutput("badlen rx_ready", int'(rx_ready), 0);
        obs_q.delete();
        rx_valid = 1'b1;
        rx_data = 8'h5A;
        repeat (3) tick();
        rx_valid = 1'b0;
        checkOutput("badlen still_not_ready", int'(rx_ready), 0);
        checkOutput("badlen no_writes", obs_q.size(), 0);
        checkOutput("badlen err_held", int'(err), 1);

        // Stray start during DATA must be ignored; reset lands mid-fill.
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("midreset ready_after_start", int'(rx_ready), 1);
        obs_q.delete();
        all_ok = 1'b1;
        applyStimulus(8'h03, 60, 1'b0, ok); all_ok &= ok;
        applyStimulus(8'h86, 60, 1'b0, ok); all_ok &= ok;
        applyStimulus(8'h45, 60, 1'b1, ok); all_ok &= ok;
        applyStimulus(8'h21, 60, 1'b0, ok); all_ok &= ok;
        applyStimulus(8'hEC, 60, 1'b0, ok); all_ok &= ok;
        checkOutput("midreset all_accepted", int'(all_ok), 1);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        checkOutput("midreset rx_ready", int'(rx_ready), 0);
        checkOutput("midreset wr_en", int'(wr_en), 0);
        checkOutput("midreset wr_addr", int'(wr_addr), 0);
        checkOutput("midreset wr_data", int'(wr_data), 0);
        checkOutput("midreset cpu_hold", int'(cpu_hold), 1);
        checkOutput("midreset done", int'(done), 0);
        checkOutput("midreset err", int'(err), 0);
        reset = 1'b0;
        exp_q = '{12'h086, 12'h145, 12'h221, 12'h300, 12'h400, 12'h500, 12'h600, 12'h700};
        compare_writes("midreset");
        tick();
        checkOutput("postreset rx_ready", int'(rx_ready), 0);
        checkOutput("postreset cpu_hold", int'(cpu_hold), 1);

        foreach (vecs[k]) begin
            make_frame(vecs[k].len, vecs[k].csum_adj);
            build_model(ed, ee, elat);
            run_frame($urandom_range(30, 100), vecs[k].exp_done, vecs[k].exp_err,
                      vecs[k].exp_lat, $sformatf("vec%0d", k));
            checkOutput($sformatf("vec%0d writes", k), obs_q.size(), vecs[k].exp_writes);
        end

        for (int r = 0; r < 25; r++) begin
            len = 8'($urandom_range(0, 18));
            adj = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            make_frame(len, adj);
            build_model(ed, ee, elat);
            run_frame($urandom_range(25, 100), ed, ee, elat, $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
